twi_slave: RTL and testbench

TWI_SLAVE -- requirements
Module: twi_slave

---
 rtl/twi_slave.sv | 203 ++++++++++++++++++++
 tb/tb_twi_slave.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twi_slave.sv
// twi_slave: two-wire bus responder exposing 8 x 8-bit registers.
// Define TWI_SLAVE_FILTER_EN to add a 3-sample glitch filter on SCL/SDA.
module twi_slave #(
  parameter logic [6:0] SLV_ADDR = 7'h50
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       TWI_SCL_I,
  input  logic       TWI_SDA_I,
  output logic       TWI_SDA_OEN,
  input  logic       LOC_WE_I,
  input  logic [2:0] LOC_ADR_I,
  input  logic [7:0] LOC_DAT_I,
  output logic [7:0] LOC_DAT_O,
  output logic       WR_EVT_O,
  output logic       BUSY_O
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE
  } state_t;

  logic [1:0] scl_sy, sda_sy;
  logic       scl_c, sda_c;
  logic       scl_h, sda_h;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
    end else begin
      scl_sy <= {scl_sy[0], TWI_SCL_I};
      sda_sy <= {sda_sy[0], TWI_SDA_I};
    end
  end

`ifdef TWI_SLAVE_FILTER_EN
  logic [1:0] scl_q, sda_q;
  logic       scl_f, sda_f;

  // a line moves only once the last 3 samples agree
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      scl_q <= 2'b11;
      sda_q <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_q <= {scl_q[0], scl_sy[1]};
      sda_q <= {sda_q[0], sda_sy[1]};
      if (scl_q == {2{scl_sy[1]}})
        scl_f <= scl_sy[1];
      if (sda_q == {2{sda_sy[1]}})
        sda_f <= sda_sy[1];
    end
  end

  assign scl_c = scl_f;
  assign sda_c = sda_f;
`else
  assign scl_c = scl_sy[1];
  assign sda_c = sda_sy[1];
`endif

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      scl_h <= 1'b1;
      sda_h <= 1'b1;
    end else begin
      scl_h <= scl_c;
      sda_h <= sda_c;
    end
  end

  logic scl_rise, scl_fall, start, stop;
  assign scl_rise = scl_c & ~scl_h;
  assign scl_fall = ~scl_c & scl_h;
  assign start = scl_c & scl_h & sda_h & ~sda_c;
  assign stop  = scl_c & scl_h & ~sda_h & sda_c;

  state_t     st;
  logic [3:0] cnt;
  logic [6:0] sh;
  logic [7:0] rsh;
  logic [2:0] ptr;
  logic       rw, mack;
  logic [7:0] regs [8];
  logic [7:0] byte_in;
  logic       bit8;

  assign byte_in = {sh, sda_c};
  assign bit8 = scl_rise && (cnt == 4'd7);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      st <= IDLE;
      cnt <= '0;
      sh <= '0;
      rsh <= '0;
      ptr <= '0;
      rw <= 1'b0;
      mack <= 1'b0;
      TWI_SDA_OEN <= 1'b0;
      WR_EVT_O <= 1'b0;
      BUSY_O <= 1'b0;
      LOC_DAT_O <= '0;
      for (int i = 0; i < 8; i++)
        regs[i] <= '0;
    end else begin
      WR_EVT_O <= 1'b0;
      LOC_DAT_O <= regs[LOC_ADR_I];
      // bus writes below override this on a same-index collision
      if (LOC_WE_I)
        regs[LOC_ADR_I] <= LOC_DAT_I;
      if (scl_rise && (st == ADDR || st == PTR || st == WDATA)) begin
        sh <= byte_in[6:0];
        cnt <= cnt + 4'd1;
      end
      if (stop) begin
        st <= IDLE;
        TWI_SDA_OEN <= 1'b0;
        BUSY_O <= 1'b0;
      end else if (start) begin
        st <= ADDR;
        cnt <= '0;
        TWI_SDA_OEN <= 1'b0;
        BUSY_O <= 1'b0;
      end else begin
        unique case (st)
          ADDR: if (bit8) begin
            rw <= byte_in[0];
            if (byte_in[7:1] == SLV_ADDR && byte_in[7:1] != 7'd0) begin
              st <= ADDR_ACK;
              BUSY_O <= 1'b1;
            end else begin
              st <= IGNORE;
            end
          end
          PTR: if (bit8) begin
            ptr <= byte_in[2:0];
            st <= PTR_ACK;
          end
          WDATA: if (bit8) begin
            regs[ptr] <= byte_in;
            WR_EVT_O <= 1'b1;
            ptr <= ptr + 3'd1;
            st <= WDATA_ACK;
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!TWI_SDA_OEN) begin
              TWI_SDA_OEN <= 1'b1;
            end else begin
              cnt <= '0;
              TWI_SDA_OEN <= 1'b0;
              if (st == ADDR_ACK && rw) begin
                st <= RDATA;
                rsh <= {regs[ptr][6:0], 1'b0};
                TWI_SDA_OEN <= ~regs[ptr][7];
              end else if (st == ADDR_ACK) begin
                st <= PTR;
              end else begin
                st <= WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_rise)
              cnt <= cnt + 4'd1;
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                TWI_SDA_OEN <= 1'b0;
                mack <= 1'b0;
                st <= RD_MACK;
              end else begin
                TWI_SDA_OEN <= ~rsh[7];
                rsh <= {rsh[6:0], 1'b0};
              end
            end
          end
          RD_MACK: begin
            if (scl_rise) begin
              if (!sda_c) begin
                mack <= 1'b1;
                ptr <= ptr + 3'd1;
              end else begin
                st <= IGNORE;
                BUSY_O <= 1'b0;
              end
            end
            if (scl_fall && mack) begin
              st <= RDATA;
              cnt <= '0;
              rsh <= {regs[ptr][6:0], 1'b0};
              TWI_SDA_OEN <= ~regs[ptr][7];
            end
          end
          IDLE, IGNORE: ;
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_twi_slave.sv
// tb_twi_slave: directed bus transactions against twi_slave.
// Table of write/read records plus hand sequences for corner cases.
module tb_twi_slave;
  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       LOC_WE_I = 1'b0;
  logic [2:0] LOC_ADR_I = '0;
  logic [7:0] LOC_DAT_I = '0;
  logic       TWI_SDA_OEN, WR_EVT_O, BUSY_O;
  logic [7:0] LOC_DAT_O;
  logic       sda_line;

  assign sda_line = sda_m & ~TWI_SDA_OEN;

  twi_slave #(.SLV_ADDR(7'h50)) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .TWI_SCL_I(scl),
    .TWI_SDA_I(sda_line),
    .TWI_SDA_OEN(TWI_SDA_OEN),
    .LOC_WE_I(LOC_WE_I),
    .LOC_ADR_I(LOC_ADR_I),
    .LOC_DAT_I(LOC_DAT_I),
    .LOC_DAT_O(LOC_DAT_O),
    .WR_EVT_O(WR_EVT_O),
    .BUSY_O(BUSY_O)
  );

  always #5 CLK_I = ~CLK_I;

  int nvec = 0;
  int nbad = 0;
  int wevt_cnt = 0;
  int oen_cnt = 0;

  always @(negedge CLK_I) begin
    if (WR_EVT_O) wevt_cnt++;
    if (TWI_SDA_OEN) oen_cnt++;
  end

  typedef struct {
    bit         rd;
    logic [2:0] ptr;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic q();
    repeat (8) @(negedge CLK_I);
  endtask

  task automatic b_start();
    sda_m = 1'b1; q();
    scl = 1'b1; q();
    sda_m = 1'b0; q();
    scl = 1'b0; q();
  endtask

  task automatic b_stop();
    sda_m = 1'b0; q();
    scl = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic wr_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; q();
      scl = 1'b1; q(); q();
      scl = 1'b0; q();
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, output bit a);
    wr_bits(b, 8);
    sda_m = 1'b1; q();
    scl = 1'b1; q();
    a = ~sda_line; q();
    scl = 1'b0; q();
  endtask

  task automatic rd_byte(input bit ack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q();
      scl = 1'b1; q();
      b[i] = sda_line; q();
      scl = 1'b0;
    end
    sda_m = ack ? 1'b0 : 1'b1; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; q();
    sda_m = 1'b1;
  endtask

  task automatic loc_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge CLK_I);
    LOC_ADR_I = a;
    @(negedge CLK_I);
    d = LOC_DAT_O;
  endtask

  task automatic loc_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge CLK_I);
    LOC_WE_I = 1'b1;
    LOC_ADR_I = a;
    LOC_DAT_I = d;
    @(negedge CLK_I);
    LOC_WE_I = 1'b0;
  endtask

  task automatic bus_wr(input logic [2:0] p, input logic [7:0] d,
                        output int acks);
    bit a;
    acks = 0;
    b_start();
    wr_byte(8'hA0, a); acks += int'(a);
    wr_byte({5'b0, p}, a); acks += int'(a);
    wr_byte(d, a); acks += int'(a);
    b_stop();
  endtask

  task automatic bus_rd(input logic [2:0] p, output logic [7:0] d,
                        output int acks);
    bit a;
    acks = 0;
    b_start();
    wr_byte(8'hA0, a); acks += int'(a);
    wr_byte({5'b0, p}, a); acks += int'(a);
    b_start();
    wr_byte(8'hA1, a); acks += int'(a);
    rd_byte(1'b0, d);
    b_stop();
  endtask

  // local write held until the bus write lands, then dropped
  task automatic collide(input logic [2:0] bp, input logic [7:0] bd,
                         input logic [2:0] la, input logic [7:0] ld);
    bit a;
    bit got;
    int acks;
    acks = 0;
    got = 1'b0;
    b_start();
    wr_byte(8'hA0, a); acks += int'(a);
    wr_byte({5'b0, bp}, a); acks += int'(a);
    fork
      wr_byte(bd, a);
      begin
        @(negedge CLK_I);
        LOC_WE_I = 1'b1;
        LOC_ADR_I = la;
        LOC_DAT_I = ld;
        for (int i = 0; i < 1000 && !got; i++) begin
          @(negedge CLK_I);
          got = WR_EVT_O;
        end
        LOC_WE_I = 1'b0;
      end
    join
    acks += int'(a);
    b_stop();
    chk("coll_acks", acks, 3);
    chk("coll_wevt", got, 1);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] d2;
    bit a;
    int acks;
    int w0, o0;

    tbl[0] = '{1'b0, 3'd4, 8'h99, 8'h99};
    tbl[1] = '{1'b0, 3'd6, 8'h0F, 8'h0F};
    tbl[2] = '{1'b1, 3'd4, 8'h00, 8'h99};
    tbl[3] = '{1'b0, 3'd0, 8'h42, 8'h42};
    tbl[4] = '{1'b1, 3'd6, 8'h00, 8'h0F};
    tbl[5] = '{1'b0, 3'd7, 8'hE1, 8'hE1};

    repeat (4) @(negedge CLK_I);
    chk("rst_oen", TWI_SDA_OEN, 0);
    chk("rst_wevt", WR_EVT_O, 0);
    chk("rst_busy", BUSY_O, 0);
    chk("rst_dat", LOC_DAT_O, 8'h00);
    RST_I = 1'b0;
    q();

    // four-byte write burst starting at reg2
    w0 = wevt_cnt;
    acks = 0;
    b_start();
    wr_byte(8'hA0, a); acks += int'(a);
    wr_byte(8'h02, a); acks += int'(a);
    wr_byte(8'h5A, a); acks += int'(a);
    wr_byte(8'hC3, a); acks += int'(a);
    chk("burst_busy", BUSY_O, 1);
    b_stop();
    chk("burst_acks", acks, 4);
    chk("burst_idle", BUSY_O, 0);
    chk("burst_wevt", wevt_cnt - w0, 2);
    loc_rd(3'd2, d);
    chk("burst_reg2", d, 8'h5A);
    loc_rd(3'd3, d);
    chk("burst_reg3", d, 8'hC3);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rd) begin
        bus_rd(tbl[i].ptr, d, acks);
        chk("tbl_rd_acks", acks, 3);
        chk("tbl_rd_dat", d, tbl[i].exp);
      end else begin
        w0 = wevt_cnt;
        bus_wr(tbl[i].ptr, tbl[i].dat, acks);
        chk("tbl_wr_acks", acks, 3);
        chk("tbl_wr_wevt", wevt_cnt - w0, 1);
        loc_rd(tbl[i].ptr, d);
        chk("tbl_wr_dat", d, tbl[i].exp);
      end
    end

    // pointer wrapped 7 -> 0 and is kept across transfers
    b_start();
    wr_byte(8'hA1, a);
    rd_byte(1'b0, d);
    b_stop();
    chk("keep_ack", a, 1);
    chk("keep_dat", d, 8'h42);

    loc_wr(3'd7, 8'h11);
    loc_wr(3'd0, 8'h22);
    acks = 0;
    b_start();
    wr_byte(8'hA0, a); acks += int'(a);
    wr_byte(8'h07, a); acks += int'(a);
    b_start();
    wr_byte(8'hA1, a); acks += int'(a);
    rd_byte(1'b1, d);
    rd_byte(1'b0, d2);
    chk("rd2_busy", BUSY_O, 0);
    chk("rd2_oen", TWI_SDA_OEN, 0);
    b_stop();
    chk("rd2_acks", acks, 3);
    chk("rd2_b0", d, 8'h11);
    chk("rd2_b1", d2, 8'h22);

    w0 = wevt_cnt;
    o0 = oen_cnt;
    acks = 0;
    b_start();
    wr_byte(8'hA2, a); acks += int'(a);
    wr_byte(8'h00, a); acks += int'(a);
    b_stop();
    b_start();
    wr_byte(8'h00, a); acks += int'(a);
    b_stop();
    chk("other_acks", acks, 0);
    chk("other_oen", oen_cnt - o0, 0);
    chk("other_wevt", wevt_cnt - w0, 0);
    loc_rd(3'd0, d);
    chk("other_reg0", d, 8'h22);

    collide(3'd1, 8'h3C, 3'd1, 8'hFF);
    loc_rd(3'd1, d);
    chk("coll_same", d, 8'h3C);
    collide(3'd6, 8'h5B, 3'd5, 8'hA5);
    loc_rd(3'd5, d);
    chk("coll_loc", d, 8'hA5);
    loc_rd(3'd6, d);
    chk("coll_bus", d, 8'h5B);

    // reset in the middle of a data byte to reg4
    b_start();
    wr_byte(8'hA0, a);
    wr_byte(8'h04, a);
    wr_bits(8'h99, 4);
    chk("mid_busy", BUSY_O, 1);
    @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    chk("mid_rst_oen", TWI_SDA_OEN, 0);
    chk("mid_rst_busy", BUSY_O, 0);
    RST_I = 1'b0;
    loc_rd(3'd4, d);
    chk("mid_rst_reg4", d, 8'h00);
    sda_m = 1'b1; q();
    scl = 1'b1; q();
    bus_wr(3'd4, 8'h77, acks);
    chk("post_rst_acks", acks, 3);
    loc_rd(3'd4, d);
    chk("post_rst_reg4", d, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
